multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables cycle by cycle.
- Stalls on a memory-ready handshake and bounds every memory wait with a timeout.
- Sits between the instruction register/opcode field and the shared multi-cycle datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode constants,
// Aluop and PcSrc codes, and the state encoding exposed on the State port.
// Build option: ILLEGAL_OP_TRAP_EN adds the TRAP state.
package mips_ctrl_pkg;

    // Opcode field values recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Aluop codes handed to the ALU control block
    localparam logic [2:0] ALUOP_FUNCT = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_ADDI  = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_SUB   = 3'b100;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; the numeric encoding is what appears on State
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_MEM = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
`else
        S_JUMP     = 4'd11
`endif
    } state_e;

    // States in which the controller waits on the memory handshake
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait timeout counter. Counts wait cycles while enabled, clears on
// request, and flags the cycle on which the wait reaches the limit.
// The flag is only raised while enabled, so a completion in the same cycle
// (which drops the enable) always wins over the timeout.
module mem_wait_timer #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tmo_o
);

    localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(MEM_TIMEOUT - 1);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    // The count already holds MEM_TIMEOUT-1 past waits: this is the last one
    assign tmo_o = en_i && (count_q == LAST_WAIT);

    // Next count: clear on request or on expiry, otherwise count waits
    always_comb begin
        count_d = count_q;
        if (clr_i || tmo_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the shared datapath enables each cycle, with a bounded memory wait.
// Build option: ILLEGAL_OP_TRAP_EN turns unknown opcodes into a sticky TRAP
// with an IllegalOp flag; otherwise unknown opcodes retire as NOPs.
//
// Memory handshake: MemRead/MemWrite are held as a request for as long as the
// controller sits in a memory state; MemReady high in such a cycle completes
// the transfer in that cycle. MemReady outside memory states is ignored.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               IrWrite,
    output logic               PcWrite,
    output logic [1:0]         PcSrc,
    output logic               RegWr,
    output logic               RegDst,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               Alusrc,
    output logic [ALUOP_W-1:0] Aluop,
    output logic               InstrDone,
    output logic               MemErr,
    output logic [3:0]         State
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic               IllegalOp
`endif
);

    localparam logic [OP_W-1:0] L_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] L_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] L_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] L_ADDI  = OP_W'(OP_ADDI);
    localparam logic [OP_W-1:0] L_ANDI  = OP_W'(OP_ANDI);
    localparam logic [OP_W-1:0] L_BEQ   = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] L_J     = OP_W'(OP_J);

    state_e            state_q;
    state_e            state_d;
    logic [OP_W-1:0]   op_q;
    logic              tmo;
    logic              tmr_en;
    logic              tmr_clr;

    // Decoded controls before the reset gate
    logic               ir_c;
    logic               pw_c;
    logic [1:0]         ps_c;
    logic               rw_c;
    logic               rd_c;
    logic               mr_c;
    logic               mw_c;
    logic               m2r_c;
    logic               as_c;
    logic [ALUOP_W-1:0] aop_c;
    logic               done_c;
    logic               err_c;

    // Timer runs only while a memory state is waiting; any state change clears it
    assign tmr_en  = is_mem_state(state_q) && !MemReady;
    assign tmr_clr = (state_d != state_q);

    mem_wait_timer #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tmo_o (tmo)
    );

    // Next-state and per-state datapath controls
    always_comb begin
        state_d = state_q;
        ir_c    = 1'b0;
        pw_c    = 1'b0;
        ps_c    = PCSRC_SEQ;
        rw_c    = 1'b0;
        rd_c    = 1'b0;
        mr_c    = 1'b0;
        mw_c    = 1'b0;
        m2r_c   = 1'b0;
        as_c    = 1'b0;
        aop_c   = ALUOP_W'(ALUOP_FUNCT);
        done_c  = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mr_c = 1'b1;
                if (MemReady) begin
                    ir_c    = 1'b1;
                    pw_c    = 1'b1;
                    ps_c    = PCSRC_SEQ;
                    state_d = S_DECODE;
                end else if (tmo) begin
                    err_c   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (op_q == L_RTYPE) begin
                    state_d = S_EXEC_R;
                end else if (op_q == L_LW || op_q == L_SW) begin
                    state_d = S_EXEC_MEM;
                end else if (op_q == L_ADDI || op_q == L_ANDI) begin
                    state_d = S_EXEC_I;
                end else if (op_q == L_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op_q == L_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = S_TRAP;
`else
                    done_c  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                aop_c   = ALUOP_W'(ALUOP_FUNCT);
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                as_c    = 1'b1;
                aop_c   = (op_q == L_ANDI) ? ALUOP_W'(ALUOP_AND) : ALUOP_W'(ALUOP_ADDI);
                state_d = S_WB_I;
            end
            S_EXEC_MEM: begin
                as_c    = 1'b1;
                aop_c   = ALUOP_W'(ALUOP_ADD);
                state_d = (op_q == L_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mr_c = 1'b1;
                if (MemReady) begin
                    state_d = S_WB_MEM;
                end else if (tmo) begin
                    err_c   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                mw_c = 1'b1;
                if (MemReady) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end else if (tmo) begin
                    err_c   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_R: begin
                rw_c    = 1'b1;
                rd_c    = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_I: begin
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                rw_c    = 1'b1;
                m2r_c   = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                aop_c   = ALUOP_W'(ALUOP_SUB);
                ps_c    = PCSRC_BRANCH;
                pw_c    = Zero;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pw_c    = 1'b1;
                ps_c    = PCSRC_JUMP;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is captured on the same edge the IR loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (state_q == S_FETCH && MemReady) begin
            op_q <= Op;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    // Sticky flag set on entry to TRAP; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE && state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign IllegalOp = illegal_q;
`endif

    // While reset is held every enable is forced low, including FETCH's MemRead
    assign IrWrite   = rst_n & ir_c;
    assign PcWrite   = rst_n & pw_c;
    assign PcSrc     = rst_n ? ps_c  : '0;
    assign RegWr     = rst_n & rw_c;
    assign RegDst    = rst_n & rd_c;
    assign MemRead   = rst_n & mr_c;
    assign MemWrite  = rst_n & mw_c;
    assign MemToReg  = rst_n & m2r_c;
    assign Alusrc    = rst_n & as_c;
    assign Aluop     = rst_n ? aop_c : '0;
    assign InstrDone = rst_n & done_c;
    assign MemErr    = rst_n & err_c;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-cycle vector table for
// the zero-wait instruction mix, then hand sequences for memory waits,
// timeouts, asynchronous reset and unknown opcodes (ILLEGAL_OP_TRAP_EN aware).
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IrWrite, PcWrite, RegWr, RegDst, MemRead, MemWrite;
    logic       MemToReg, Alusrc, InstrDone, MemErr;
    logic [1:0] PcSrc;
    logic [2:0] Aluop;
    logic [3:0] State;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       IllegalOp;
`endif

    multicycle_control_unit #(
        .OP_W(6), .ALUOP_W(3), .TMO_W(4), .MEM_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Op        (Op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .IrWrite   (IrWrite),
        .PcWrite   (PcWrite),
        .PcSrc     (PcSrc),
        .RegWr     (RegWr),
        .RegDst    (RegDst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemToReg  (MemToReg),
        .Alusrc    (Alusrc),
        .Aluop     (Aluop),
        .InstrDone (InstrDone),
        .MemErr    (MemErr),
        .State     (State)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .IllegalOp (IllegalOp)
`endif
    );

    // Clock: 10 ns period, first rising edge at 5 ns
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control bundle, in the field order used by ctl()
    logic [14:0] got_ctl;
    assign got_ctl = {IrWrite, PcWrite, PcSrc, RegWr, RegDst, MemRead, MemWrite,
                      MemToReg, Alusrc, Aluop, InstrDone, MemErr};

    typedef struct packed {
        logic        rdy;
        logic [5:0]  op;
        logic        z;
        logic [3:0]  st;
        logic [14:0] c;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc_n   = 0;
    int   done_at = 0;

    localparam logic [5:0] XX = 6'h3F;

    function automatic logic [14:0] ctl(input logic ir, input logic pw, input logic [1:0] ps,
                                        input logic rw, input logic rd, input logic mr,
                                        input logic mw, input logic m2r, input logic as_,
                                        input logic [2:0] aop, input logic done, input logic err);
        return {ir, pw, ps, rw, rd, mr, mw, m2r, as_, aop, done, err};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
        end
    endtask

    // One clock: drive inputs (entered at posedge+1), check at negedge, leave at posedge+1
    task automatic cyc(input logic rdy, input logic [5:0] op, input logic z,
                       input logic [3:0] st, input logic [14:0] c, input string nm);
        MemReady = rdy;
        Op       = op;
        Zero     = z;
        @(negedge clk);
        cyc_n++;
        check({nm, "_state"}, 32'(State), 32'(st));
        check({nm, "_ctl"}, 32'(got_ctl), 32'(c));
        if (InstrDone && done_at == 0) done_at = cyc_n;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rdy, input logic [5:0] op, input logic z,
                       input logic [3:0] st, input logic [14:0] c);
        vec_t v;
        v.rdy = rdy; v.op = op; v.z = z; v.st = st; v.c = c;
        vecs.push_back(v);
    endtask

    initial begin
        logic [14:0] c_fetch, c_wait, c_zero;
        c_fetch = ctl(1, 1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0, 0);
        c_wait  = ctl(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0, 0);
        c_zero  = '0;

        // R-type: 4 cycles, write rd in the last
        add(1, 6'b000000, 1, S_FETCH,  c_fetch);
        add(1, XX,        1, S_DECODE, c_zero);
        add(0, XX,        1, S_EXEC_R, c_zero);
        add(1, XX,        1, S_WB_R,   ctl(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 3'b000, 1, 0));
        // addi
        add(1, 6'b001000, 0, S_FETCH,  c_fetch);
        add(0, XX,        0, S_DECODE, c_zero);
        add(1, XX,        0, S_EXEC_I, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0));
        add(0, XX,        0, S_WB_I,   ctl(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        // andi
        add(1, 6'b001100, 0, S_FETCH,  c_fetch);
        add(1, XX,        0, S_DECODE, c_zero);
        add(0, XX,        0, S_EXEC_I, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b011, 0, 0));
        add(1, XX,        0, S_WB_I,   ctl(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        // lw, zero wait: 5 cycles
        add(1, 6'b100011, 1, S_FETCH,    c_fetch);
        add(0, XX,        1, S_DECODE,   c_zero);
        add(0, XX,        1, S_EXEC_MEM, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0));
        add(1, XX,        1, S_MEM_RD,   c_wait);
        add(0, XX,        1, S_WB_MEM,   ctl(0, 0, 2'b00, 1, 0, 0, 0, 1, 0, 3'b000, 1, 0));
        // sw: 4 cycles, never RegWr
        add(1, 6'b101011, 0, S_FETCH,    c_fetch);
        add(1, XX,        0, S_DECODE,   c_zero);
        add(1, XX,        0, S_EXEC_MEM, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0));
        add(1, XX,        0, S_MEM_WR,   ctl(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 3'b000, 1, 0));
        // beq taken
        add(1, 6'b000100, 0, S_FETCH,  c_fetch);
        add(0, XX,        0, S_DECODE, c_zero);
        add(0, XX,        1, S_BRANCH, ctl(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0));
        // beq not taken
        add(1, 6'b000100, 1, S_FETCH,  c_fetch);
        add(1, XX,        1, S_DECODE, c_zero);
        add(1, XX,        0, S_BRANCH, ctl(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0));
        // j
        add(1, 6'b000010, 0, S_FETCH,  c_fetch);
        add(0, XX,        0, S_DECODE, c_zero);
        add(1, XX,        0, S_JUMP,   ctl(0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));

        // Reset state, asynchronous and with every enable low
        rst_n = 1'b0; Op = '0; Zero = 1'b0; MemReady = 1'b0;
        #3;
        check("reset_state", 32'(State), 32'(S_FETCH));
        check("reset_ctl", 32'(got_ctl), 32'(c_zero));
`ifdef ILLEGAL_OP_TRAP_EN
        check("reset_illegal", 32'(IllegalOp), 32'(0));
`endif
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);
        check("release_memread", 32'(got_ctl), 32'(c_wait));
        @(posedge clk); #1;

        // Zero-wait instruction mix
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rdy, vecs[i].op, vecs[i].z, vecs[i].st, vecs[i].c, $sformatf("vec%0d", i));
        end

        // lw with MemReady held off 3 cycles in MEM_RD: 8 cycles total
        cyc_n = 0; done_at = 0;
        cyc(1, 6'b100011, 0, S_FETCH,    c_fetch, "lwd_fetch");
        cyc(0, XX,        0, S_DECODE,   c_zero,  "lwd_decode");
        cyc(0, XX,        0, S_EXEC_MEM, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0), "lwd_exec");
        for (int i = 0; i < 3; i++) cyc(0, XX, 0, S_MEM_RD, c_wait, "lwd_wait");
        cyc(1, XX,        0, S_MEM_RD,   c_wait,  "lwd_ready");
        cyc(0, XX,        0, S_WB_MEM,   ctl(0, 0, 2'b00, 1, 0, 0, 0, 1, 0, 3'b000, 1, 0), "lwd_wb");
        check("lwd_latency", 32'(done_at), 32'(8));

        // MemReady stuck low in FETCH: MemErr on the 15th wait cycle, no IR load
        for (int i = 1; i <= 14; i++) cyc(0, 6'b000010, 0, S_FETCH, c_wait, $sformatf("ftmo_w%0d", i));
        cyc(0, 6'b000010, 0, S_FETCH, ctl(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0, 1), "ftmo_err");
        // Restarted wait: MemReady arrives on wait cycle 15, completion wins
        for (int i = 1; i <= 14; i++) cyc(0, 6'b000010, 0, S_FETCH, c_wait, $sformatf("fok_w%0d", i));
        cyc(1, 6'b000010, 0, S_FETCH,  c_fetch, "fok_ready15");
        cyc(0, XX,        0, S_DECODE, c_zero,  "fok_decode");
        cyc(0, XX,        0, S_JUMP,   ctl(0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0), "fok_jump");

        // lw whose data never arrives: abort from MEM_RD, no register write
        cyc(1, 6'b100011, 0, S_FETCH,    c_fetch, "rtmo_fetch");
        cyc(1, XX,        0, S_DECODE,   c_zero,  "rtmo_decode");
        cyc(1, XX,        0, S_EXEC_MEM, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0), "rtmo_exec");
        for (int i = 1; i <= 14; i++) cyc(0, XX, 0, S_MEM_RD, c_wait, $sformatf("rtmo_w%0d", i));
        cyc(0, XX, 0, S_MEM_RD, ctl(0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 0, 1), "rtmo_err");
        cyc(0, XX, 0, S_FETCH,  c_wait, "rtmo_back");

        // Reset asserted mid-EXEC_R
        cyc(1, 6'b000000, 0, S_FETCH,  c_fetch, "mrst_fetch");
        cyc(0, XX,        0, S_DECODE, c_zero,  "mrst_decode");
        #2; rst_n = 1'b0; MemReady = 1'b1;
        #1;
        check("mrst_async_state", 32'(State), 32'(S_FETCH));
        check("mrst_async_ctl", 32'(got_ctl), 32'(c_zero));
        @(posedge clk); #2; rst_n = 1'b1; MemReady = 1'b0;
        @(negedge clk);
        check("mrst_release_state", 32'(State), 32'(S_FETCH));
        check("mrst_release_ctl", 32'(got_ctl), 32'(c_wait));
        @(posedge clk); #1;

        // Unknown opcode 111111
        cyc(1, 6'b111111, 0, S_FETCH, c_fetch, "ill_fetch");
`ifdef ILLEGAL_OP_TRAP_EN
        cyc(1, XX, 0, S_DECODE, c_zero, "ill_decode");
        for (int i = 0; i < 3; i++) begin
            cyc(1, XX, 1, S_TRAP, c_zero, "ill_trap");
            check("ill_flag", 32'(IllegalOp), 32'(1));
        end
        #2; rst_n = 1'b0;
        #1;
        check("ill_flag_reset", 32'(IllegalOp), 32'(0));
        check("ill_reset_state", 32'(State), 32'(S_FETCH));
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;
`else
        cyc(1, XX, 0, S_DECODE, ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0), "nop_decode");
        cyc(0, XX, 0, S_FETCH,  c_wait, "nop_back");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
